// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared definitions for the direct-mapped cache controller.
//   - FSM state encoding (4-bit, exported on the controller's state port)
//   - default geometry (address width, index width, derived tag width)
//   - width of the optional statistics counters
package cache_ctrl_pkg;

    localparam int MEMORY_BITS_DEF = 5;
    localparam int INDEX_DEF       = 3;
    localparam int CACHE_SIZE_DEF  = 1 << INDEX_DEF;
    localparam int TAG_W_DEF       = MEMORY_BITS_DEF - INDEX_DEF;
    localparam int STAT_W          = 16;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOOKUP  = 4'd1,
        S_COMPARE = 4'd2,
        S_MEM_RD  = 4'd3,
        S_FILL    = 4'd4,
        S_MEM_WR  = 4'd5,
        S_DONE    = 4'd6
    } state_t;

endpackage

// File: rtl/cache_stat_counter.sv
// cache_stat_counter: saturating event counter.
//   clk    in  clock
//   rst_n  in  asynchronous active-low clear
//   en     in  count one event this cycle
//   count  out current value, sticks at all-ones
module cache_stat_counter
    import cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {STAT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// cache_controller: sequencing FSM for a direct-mapped cache whose tag and
// valid arrays live in external RAMs. Write-through, no-write-allocate.
//   clk, reset              clock, asynchronous active-low reset
//   read_signal/write_signal CPU request levels (read wins if both)
//   cpu_addr                CPU address, latched when the request is taken
//   busy, done, hit         status; hit is meaningful while done=1
//   state                   FSM state code, also fed to the RAMs
//   cache_addr, taginput,
//   write_signal_cache      tag/valid RAM index, fill tag, write enable
//   tagoutput, validoutput  RAM read data (RAMs update on the negedge)
//   mem_req/mem_we/mem_addr/
//   mem_ack                 backing-memory handshake
// Optional: define CACHE_CTRL_STATS_EN to add hit_count/miss_count outputs
// (saturating counts of completed reads).
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int memory_bits = MEMORY_BITS_DEF,
    parameter int cache_size  = CACHE_SIZE_DEF,
    parameter int index       = INDEX_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         read_signal,
    input  logic                         write_signal,
    input  logic [memory_bits-1:0]       cpu_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         hit,
    output logic [3:0]                   state,
    output logic [index-1:0]             cache_addr,
    output logic [memory_bits-index-1:0] taginput,
    output logic                         write_signal_cache,
    input  logic [memory_bits-index-1:0] tagoutput,
    input  logic                         validoutput,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [memory_bits-1:0]       mem_addr,
`ifdef CACHE_CTRL_STATS_EN
    output logic [STAT_W-1:0]            hit_count,
    output logic [STAT_W-1:0]            miss_count,
`endif
    input  logic                         mem_ack
);

    // Geometry sanity check: line count must match the index width.
    if (cache_size != (1 << index)) begin : g_bad_geometry
        $error("cache_controller: cache_size must equal 2**index");
    end

    state_t                 state_q, state_d;
    logic [memory_bits-1:0] addr_q, addr_d;
    logic                   op_rd_q, op_rd_d;
    logic                   hit_q, hit_d;
    logic                   done_q, done_d;
    logic                   wsc_q, wsc_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic                   tag_match;

    assign tag_match = validoutput && (tagoutput == addr_q[memory_bits-1:index]);

    // All outputs are registered: each *_d describes what the output must
    // be while the FSM sits in state_d.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_rd_d   = op_rd_q;
        hit_d     = hit_q;
        done_d    = 1'b0;
        wsc_d     = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                hit_d = 1'b0;
                if (read_signal || write_signal) begin
                    addr_d  = cpu_addr;
                    op_rd_d = read_signal;   // a simultaneous write is dropped
                    state_d = S_LOOKUP;
                end
            end
            // cache_addr already shows the latched index; the RAMs respond
            // on this cycle's negedge, so the compare waits one state.
            S_LOOKUP: state_d = S_COMPARE;
            S_COMPARE: begin
                hit_d = tag_match;
                if (!op_rd_q) begin
                    state_d   = S_MEM_WR;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end else if (tag_match) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_MEM_RD;
                    mem_req_d = 1'b1;
                end
            end
            S_MEM_RD: begin
                if (mem_req_q && mem_ack) begin
                    state_d = S_FILL;
                    wsc_d   = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_req_q && mem_ack) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            S_FILL: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                hit_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            op_rd_q   <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
            wsc_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_rd_q   <= op_rd_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
            wsc_q     <= wsc_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign hit                = hit_q;
    assign state              = state_q;
    assign cache_addr         = addr_q[index-1:0];
    assign taginput           = addr_q[memory_bits-1:index];
    assign write_signal_cache = wsc_q;
    assign mem_req            = mem_req_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = addr_q;

`ifdef CACHE_CTRL_STATS_EN
    // Reads are classified in DONE, where hit_q still holds the lookup result.
    logic rd_done;
    assign rd_done = (state_q == S_DONE) && op_rd_q;

    cache_stat_counter u_hit_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (rd_done && hit_q),
        .count (hit_count)
    );

    cache_stat_counter u_miss_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (rd_done && !hit_q),
        .count (miss_count)
    );
`endif

endmodule
